// File: rtl/register_file.sv
// Two-read, one-write register file with a hard-wired zero register.
// Asynchronous active-low reset clears every entry; reads are purely combinational.
module register_file #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    // Writes to address 0 are dropped here, so entry 0 never leaves its reset value.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-through bypass: a same-cycle write becomes visible only after the edge.
    assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read values into a
// queue and a separate monitor process pops and compares them against the DUT.
module tb_register_file;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset_n;
    logic              reg_write;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WIDTH-1:0]  rd_data1;
    logic [WIDTH-1:0]  rd_data2;

    register_file #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .reg_write(reg_write),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] exp1;
        logic [WIDTH-1:0] exp2;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: drains the scoreboard each time the stimulus announces a settled read.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rd_data1 !== e.exp1 || rd_data2 !== e.exp2) begin
                    n_fail++;
                    $display("FAIL %s: rd_data1=%h rd_data2=%h, required %h %h",
                             e.name, rd_data1, rd_data2, e.exp1, e.exp2);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input logic [ADDR_W-1:0] a1,
                             input logic [ADDR_W-1:0] a2,
                             input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
        exp_t e;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
        e.name = name;
        e.exp1 = e1;
        e.exp2 = e2;
        exp_q.push_back(e);
        ->chk_ev;
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        reg_write = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        reset_n   = 1'b0;
        reg_write = 1'b1;
        wr_addr   = 5'd1;
        wr_data   = 32'hFFFF_FFFF;
        rd_addr1  = '0;
        rd_addr2  = '0;

        // Reset held with a write pending: every address reads zero across several edges.
        for (int unsigned i = 1; i < 32; i++) begin
            a = 5'(i);
            expect_rd("reset_all", a, 5'(31 - i + 1), '0, '0);
        end

        @(negedge clk);
        reg_write = 1'b0;
        reset_n   = 1'b1;

        wr(5'd5, 32'hDEAD_BEEF);
        wr(5'd6, 32'h1234_5678);
        expect_rd("write_read_r5_r6", 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h1234_5678);
        expect_rd("same_addr_both", 5'd6, 5'd6, 32'h1234_5678, 32'h1234_5678);
        for (int unsigned i = 0; i < 32; i++) begin
            if (i != 5 && i != 6) begin
                a = 5'(i);
                expect_rd("others_zero", a, a, '0, '0);
            end
        end

        wr(5'd0, 32'hFFFF_FFFF);
        expect_rd("zero_reg", 5'd0, 5'd5, '0, 32'hDEAD_BEEF);

        wr(5'd7, 32'h0000_AAAA);
        @(negedge clk);
        reg_write = 1'b0;
        wr_addr   = 5'd7;
        wr_data   = 32'h5555_5555;
        @(negedge clk);
        expect_rd("enable_off", 5'd7, 5'd6, 32'h0000_AAAA, 32'h1234_5678);

        wr(5'd9, 32'h1111_1111);
        @(negedge clk);
        reg_write = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'h2222_2222;
        expect_rd("rdw_before", 5'd9, 5'd7, 32'h1111_1111, 32'h0000_AAAA);
        @(posedge clk);
        #1;
        expect_rd("rdw_after", 5'd9, 5'd9, 32'h2222_2222, 32'h2222_2222);
        @(negedge clk);
        reg_write = 1'b0;

        @(negedge clk);
        reg_write = 1'b1;
        wr_addr   = 5'd10;
        wr_data   = 32'h0000_0001;
        @(negedge clk);
        wr_data   = 32'h0000_0002;
        @(negedge clk);
        reg_write = 1'b0;
        expect_rd("back_to_back", 5'd10, 5'd9, 32'h0000_0002, 32'h2222_2222);

        wr(5'd11, 32'h8000_0001);
        wr(5'd31, 32'hA5A5_5A5A);
        expect_rd("full_width", 5'd11, 5'd31, 32'h8000_0001, 32'hA5A5_5A5A);

        wr(5'd3, 32'hCAFE_F00D);
        expect_rd("pre_async", 5'd3, 5'd5, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        @(negedge clk);
        reg_write = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'h0000_1234;
        #1;
        reset_n = 1'b0;
        expect_rd("async_immediate", 5'd3, 5'd5, '0, '0);
        @(posedge clk);
        #1;
        expect_rd("async_after_edge", 5'd3, 5'd31, '0, '0);
        @(negedge clk);
        reg_write = 1'b0;
        reset_n   = 1'b1;

        wr(5'd3, 32'h5A5A_0F0F);
        expect_rd("first_write_after_reset", 5'd3, 5'd9, 32'h5A5A_0F0F, '0);

        #5;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width; register count SHALL be 2**ADDR_W (32 by default).
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes except reset SHALL occur on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port reg_write  input  1  SHALL be the write enable, sampled at the rising edge of clk.
REQ-006 Port wr_addr  input  ADDR_W  SHALL select the register to write.
REQ-007 Port wr_data  input  WIDTH  SHALL carry the value to write.
REQ-008 Port rd_addr1  input  ADDR_W  SHALL select the register for read port 1.
REQ-009 Port rd_addr2  input  ADDR_W  SHALL select the register for read port 2.
REQ-010 Port rd_data1  output  WIDTH  SHALL carry the contents of the register at rd_addr1.
REQ-011 Port rd_data2  output  WIDTH  SHALL carry the contents of the register at rd_addr2.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of WIDTH bits each, one per register address.
REQ-013 A write SHALL occur at a clk rising edge iff reset_n=1 and reg_write=1: register[wr_addr] <= wr_data.
REQ-014 With reg_write=0 at an edge, no register SHALL change.
REQ-015 Register 0 SHALL read as all zeros at all times; writes to address 0 SHALL be discarded without side effects.
REQ-016 Read ports SHALL be combinational: rd_dataN SHALL follow rd_addrN and the stored contents with zero clock latency.
REQ-017 Each read port SHALL be a 2**ADDR_W:1 selection over register outputs; the two ports SHALL be fully independent, and rd_addr1 may equal rd_addr2.
REQ-018 Read-during-write (rd_addrN == wr_addr, reg_write=1): rd_dataN SHALL show the old value before the edge and the new value after it; no write-through bypass.
REQ-019 Each write SHALL change exactly one register; all other registers SHALL hold their values.
REQ-020 Consecutive writes to the same address on successive edges SHALL leave the last written value.
REQ-021 wr_data SHALL be stored unmodified at full WIDTH; no truncation or sign extension.

Reset
REQ-022 While reset_n=0, every register SHALL be 0 and both rd_data outputs SHALL be 0, independent of clk.
REQ-023 Assertion of reset_n SHALL clear all registers immediately, including mid-cycle while a write is pending; reset SHALL win over a simultaneous write.
REQ-024 After reset_n deasserts, the first write SHALL take effect on the first clk rising edge sampled with reset_n=1 and reg_write=1.

Verification
REQ-025 Reset: drive reset_n=0, all addresses 1..31 on both ports -> rd_data1=rd_data2=0x00000000 throughout.
REQ-026 Write/read: write 0xDEADBEEF to r5 and 0x12345678 to r6; rd_addr1=5, rd_addr2=6 -> 0xDEADBEEF and 0x12345678; all other registers remain 0.
REQ-027 Zero register: write 0xFFFFFFFF to r0 -> rd_data1 with rd_addr1=0 reads 0x00000000.
REQ-028 Enable off: r7=0x0000AAAA, then reg_write=0, wr_addr=7, wr_data=0x55555555, one edge -> r7 still 0x0000AAAA.
REQ-029 Read-during-write: r9=0x11111111, write 0x22222222 to r9 with rd_addr1=9 -> 0x11111111 before the edge, 0x22222222 after it.
REQ-030 Async reset mid-operation: r3=0xCAFEF00D, pull reset_n low between edges with reg_write=1 -> rd_data for r3 is 0 immediately and after the following edge.
